// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row drive, column sync, debounce, key strobe and held flag.
// Optional auto-repeat while a key is held is compiled in with `define KEYPAD_REPEAT_EN.

module keypad_col_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  // Idle level of a pulled-up column is high, so the flops reset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module keypad_scanner #(
  parameter int SCAN_DIV      = 50000,
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int NUM_COLS = 4;
  localparam int CNT_MAX  = (SCAN_DIV > DEB_CYCLES) ? SCAN_DIV : DEB_CYCLES;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, HOLD = 2'd2} state_t;

  state_t              state, state_d;
  logic [NUM_COLS-1:0] col_s;
  logic [CW-1:0]       cnt, cnt_d;
  logic [3:0]          row_d, row_rot, key_code_d;
  logic [1:0]          lat_row, lat_row_d, lat_col, lat_col_d;
  logic [1:0]          row_idx, low_col;
  logic                key_valid_d, key_held_d;
  logic                any_low, lat_bit, scan_last, deb_last;
  logic                rep_fire;

  if (SCAN_DIV < 4 || DEB_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("keypad_scanner: parameter out of range");
  end

  for (genvar g = 0; g < NUM_COLS; g++) begin : g_sync
    keypad_col_sync u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (col[g]),
      .q    (col_s[g])
    );
  end

  assign any_low   = (col_s != 4'hF);
  assign lat_bit   = col_s[lat_col];
  assign scan_last = (cnt == SCAN_LAST);
  assign deb_last  = (cnt == DEB_LAST);
  assign row_rot   = {row[2:0], row[3]};

  always_comb begin
    unique case (row)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  // Lowest-indexed low column wins when several are pressed on one row.
  always_comb begin
    low_col = 2'd0;
    for (int i = NUM_COLS - 1; i >= 0; i--)
      if (!col_s[i]) low_col = 2'(i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SCAN;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      SCAN:     if (scan_last && any_low) state_d = DEBOUNCE;
      DEBOUNCE: if (lat_bit)              state_d = SCAN;
                else if (deb_last)        state_d = HOLD;
      HOLD:     if (lat_bit && deb_last)  state_d = SCAN;
      default:                            state_d = SCAN;
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_cnt, rep_cnt_d;

  // Runs only while HOLD persists; the exit cycle clears it and never fires.
  always_comb begin
    rep_cnt_d = '0;
    rep_fire  = 1'b0;
    if (state == HOLD && state_d == HOLD) begin
      if (rep_cnt == REP_LAST) rep_fire  = 1'b1;
      else                     rep_cnt_d = rep_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rep_cnt <= '0;
    else       rep_cnt <= rep_cnt_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    cnt_d       = cnt;
    row_d       = row;
    lat_row_d   = lat_row;
    lat_col_d   = lat_col;
    key_code_d  = key_code;
    key_valid_d = rep_fire;
    key_held_d  = key_held;
    unique case (state)
      SCAN: begin
        if (scan_last) begin
          cnt_d = '0;
          if (any_low) begin
            lat_row_d = row_idx;
            lat_col_d = low_col;
          end else begin
            row_d = row_rot;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (lat_bit) begin
          cnt_d = '0;
          row_d = row_rot;
        end else if (deb_last) begin
          cnt_d       = '0;
          key_code_d  = {lat_row, lat_col};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      HOLD: begin
        // Release counter: any low sample restarts the stable-high run.
        if (!lat_bit) begin
          cnt_d = '0;
        end else if (deb_last) begin
          cnt_d      = '0;
          key_held_d = 1'b0;
          row_d      = row_rot;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
        row_d = 4'b1110;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      row       <= 4'b1110;
      lat_row   <= 2'd0;
      lat_col   <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      row       <= row_d;
      lat_row   <= lat_row_d;
      lat_col   <= lat_col_d;
      key_code  <= key_code_d;
      key_valid <= key_valid_d;
      key_held  <= key_held_d;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a small keypad matrix model feeds col from row and the pressed-key map.
module tb_keypad_scanner;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col, row, key_code;
  logic       key_valid, key_held;
  logic [3:0][3:0] pressed;  // [row][col], 1 = key down

  int checks = 0, failures = 0;
  int strobes = 0, dbl = 0;
  logic prev_v = 1'b0;

  typedef struct {
    int         r;
    logic [3:0] cols;
    logic [3:0] exp_code;
  } press_vec_t;

  press_vec_t vecs [6];

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEB_CYCLES(8), .REPEAT_CYCLES(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .col      (col),
    .row      (row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !row[r]) col[c] = 1'b0;
  end

  always @(posedge clk) begin
    if (key_valid) strobes++;
    if (key_valid && prev_v) dbl++;
    prev_v = key_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int bound, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < bound && !ok) begin
      tick(1);
      n++;
      if (key_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_held_fall(input string name);
    int n = 0;
    while (key_held && n < 40) begin
      tick(1);
      n++;
    end
    chk(name, key_held, 1'b0);
  endtask

  task automatic wait_row_start(input logic [3:0] target, output bit ok);
    logic [3:0] prev;
    prev = row;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(1);
      if (row == target && prev != target) ok = 1'b1;
      prev = row;
    end
  endtask

  initial begin
    int n, base, exp_n;
    bit ok;
    logic [3:0] exp_row, one;

    vecs[0] = '{0, 4'b0001, 4'h0};
    vecs[1] = '{1, 4'b0100, 4'h6};
    vecs[2] = '{2, 4'b1000, 4'hB};
    vecs[3] = '{3, 4'b0011, 4'hC};
    vecs[4] = '{3, 4'b1000, 4'hF};
    vecs[5] = '{1, 4'b1010, 4'h5};

    pressed = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_row", row, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    reset = 1'b0;

    one = 4'b0001;
    for (int i = 1; i <= 64; i++) begin
      tick(1);
      exp_row = ~(one << ((i / 4) % 4));
      chk("scan_row", row, exp_row);
    end
    chk("scan_no_valid", strobes, 0);

    // Key (1,2) down from reset release: row 1 sampled at edge 8, strobe after edge 16.
    reset = 1'b1;
    pressed[1][2] = 1'b1;
    repeat (2) @(negedge clk);
    base = strobes;
    reset = 1'b0;
    wait_valid(100, n, ok);
    chk("lat_found", ok, 1'b1);
    chk("lat_cycles", n, 16);
    chk("lat_code", key_code, 4'h6);
    chk("lat_held", key_held, 1'b1);
    tick(50 - n);
    pressed = '0;
    tick(9);
    chk("rel_held_9", key_held, 1'b1);
    tick(1);
    chk("rel_held_10", key_held, 1'b0);
    chk("rel_row", row, 4'b1011);
    tick(10);
`ifdef KEYPAD_REPEAT_EN
    exp_n = 2;
`else
    exp_n = 1;
`endif
    chk("long_press_strobes", strobes - base, exp_n);
    chk("long_press_code", key_code, 4'h6);

    for (int v = 0; v < 6; v++) begin
      base = strobes;
      pressed[vecs[v].r] = vecs[v].cols;
      wait_valid(100, n, ok);
      chk("vec_found", ok, 1'b1);
      chk("vec_code", key_code, vecs[v].exp_code);
      chk("vec_held", key_held, 1'b1);
      tick(20);
      pressed = '0;
      wait_held_fall("vec_held_fall");
      tick(2);
      chk("vec_strobes", strobes - base, 1);
      chk("vec_code_kept", key_code, vecs[v].exp_code);
    end

    // Bounce: three low samples then high inside DEBOUNCE.
    base = strobes;
    wait_row_start(4'b1110, ok);
    chk("bounce_sync", ok, 1'b1);
    tick(1);
    pressed[0][1] = 1'b1;
    tick(3);
    pressed = '0;
    tick(3);
    chk("bounce_row_next", row, 4'b1101);
    chk("bounce_held", key_held, 1'b0);
    tick(4);
    chk("bounce_row_scan", row, 4'b1011);
    tick(10);
    chk("bounce_strobes", strobes - base, 0);

    // Reset while debouncing key (2,3).
    wait_row_start(4'b1011, ok);
    chk("rstdeb_sync", ok, 1'b1);
    base = strobes;
    pressed[2][3] = 1'b1;
    tick(6);
    chk("rstdeb_row_frozen", row, 4'b1011);
    #1 reset = 1'b1;
    #1;
    chk("rstdeb_row", row, 4'b1110);
    chk("rstdeb_held", key_held, 1'b0);
    chk("rstdeb_valid", key_valid, 1'b0);
    chk("rstdeb_code", key_code, 4'h0);
    pressed = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick(30);
    chk("rstdeb_strobes", strobes - base, 0);
    base = strobes;
    pressed[2][3] = 1'b1;
    wait_valid(100, n, ok);
    chk("rstdeb_next_found", ok, 1'b1);
    chk("rstdeb_next_code", key_code, 4'hB);
    tick(20);
    pressed = '0;
    wait_held_fall("rstdeb_held_fall");
    tick(2);
    chk("rstdeb_next_strobes", strobes - base, 1);

    // Long hold of key 0 for 100 cycles after acceptance.
    base = strobes;
    pressed[0][0] = 1'b1;
    wait_valid(100, n, ok);
    chk("rep_found", ok, 1'b1);
    tick(100);
    pressed = '0;
    wait_held_fall("rep_held_fall");
    tick(2);
`ifdef KEYPAD_REPEAT_EN
    exp_n = 4;
`else
    exp_n = 1;
`endif
    chk("rep_strobes", strobes - base, exp_n);
    chk("rep_code", key_code, 4'h0);
    chk("no_double_strobe", dbl, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad input scanner for the clock's time-setting path: drives the rows of a 4x4 active-low keypad, reads the columns, debounces one key at a time and emits a one-cycle strobe with a 4-bit key code. It is the input-side counterpart of the multiplexed display scan: the display drives digit selects outward, this block drives row selects and reads the matrix back. Its output feeds the time-set logic that loads digits into the running clock.

## Interface
- SCAN_DIV, 50000: clk cycles each row is driven before advancing (>=4).
- DEB_CYCLES, 500000: consecutive stable clk cycles required to accept a press or a release.
- REPEAT_CYCLES, 25000000: auto-repeat period while held (used only with the macro below).
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- col  input  4  column lines, active-low (pulled up externally); asynchronous to clk.
- row  output  4  row drive, one-hot active-low.
- key_code  output  4  {row_index[1:0], col_index[1:0]} of the last accepted key.
- key_valid  output  1  one-cycle strobe; key_code is valid in the same cycle.
- key_held  output  1  high from acceptance until release is debounced.

## Operation
- col passes through a 2-FF synchronizer (col_s); all decisions use col_s.
- Reset values: row=4'b1110, key_code=0, key_valid=0, key_held=0, state SCAN, all counters 0, synchronizer flops 4'hF.
- SCAN: scan counter counts 0..SCAN_DIV-1; at SCAN_DIV-1 col_s is sampled. If col_s==4'hF, row rotates left (1110->1101->1011->0111->1110) and counter clears. Otherwise latch row index and lowest-indexed low column bit, hold row, go DEBOUNCE.
- DEBOUNCE: counter counts cycles with the latched col_s bit low. Latched bit going high -> clear counter, rotate row, back to SCAN (bounce rejected). Count reaching DEB_CYCLES -> load key_code, pulse key_valid, set key_held, go HOLD.
- HOLD: row stays fixed; other keys ignored. Release counter counts cycles with the latched col_s bit high, clears when it goes low. Reaching DEB_CYCLES -> key_held=0, rotate row, SCAN.
- Multiple simultaneous columns on one row: lowest index wins. Keys on other rows are not seen until HOLD exits.
- key_code holds its value after release until the next accepted key.

## Timing
- Press latency: key_valid asserts exactly DEB_CYCLES+1 cycles after the SCAN sample cycle that detected the key, plus 2 synchronizer cycles from a stable col edge.
- key_valid is never high for two consecutive cycles.
- key_held falls DEB_CYCLES+2 cycles after the col line returns high (stable).
- reset mid-DEBOUNCE or mid-HOLD: outputs return to reset values asynchronously; no key_valid is produced for the interrupted press; scanning restarts at row 0.
- Counters wide enough for the parameter values (use $clog2); no wrap in any state.

## Configuration
- KEYPAD_REPEAT_EN defined: in HOLD, a repeat counter runs from acceptance; every REPEAT_CYCLES cycles held, key_valid pulses again with the unchanged key_code. Counter clears on release or reset.
- Not defined: exactly one key_valid per press; no repeat counter synthesized.

## Test plan
Bench parameters: SCAN_DIV=4, DEB_CYCLES=8, REPEAT_CYCLES=32.
- Reset, no keys for 64 cycles -> row cycles 1110,1101,1011,0111 every 4 cycles; key_valid never asserted.
- Hold col=4'b1011 while row=1101 (row 1, col 2), release after 50 cycles -> single key_valid with key_code=4'h6; key_held high until 10 cycles after release.
- Col bit low for 3 cycles then high (bounce) -> no key_valid; scanning resumes with next row.
- Col=4'b1100 on row 3 -> key_code=4'hC (column 0 wins).
- Assert reset during DEBOUNCE -> row=1110, key_held=0, no key_valid; next clean press accepted normally.
- With KEYPAD_REPEAT_EN, hold key 4'h0 for 100 cycles -> key_valid at acceptance and then every 32 cycles (4 strobes total), all with key_code=4'h0; without the macro, exactly 1 strobe.
